// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: datapath width, register index width,
// ABI register indices and architectural reset values for sp/gp.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 2;
  localparam int unsigned REG_GP   = 3;

  localparam logic [XLEN-1:0] SP_RESET_VAL = 32'h7FFF_EFFC;
  localparam logic [XLEN-1:0] GP_RESET_VAL = 32'h1000_8000;

endpackage

// File: rtl/register_file_decoder.sv
// Write-enable decoder: one-hot select of the destination entry, gated by
// the write strobe; entry 0 (x0) is never enabled.
module reg_write_decoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic                 reg_write_i,
  input  logic [ADDR_W-1:0]    write_reg_i,
  output logic [2**ADDR_W-1:0] write_en_o
);

  always_comb begin
    write_en_o = '0;
    if (reg_write_i) begin
      write_en_o[write_reg_i] = 1'b1;
    end
    write_en_o[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/register_file.sv
// Architectural integer register file: 2 combinational read ports with
// write-through bypass, 1 synchronous write port, x0 hardwired to zero.
module register_file
  import riscv_pkg::*;
#(
  parameter int unsigned     N        = XLEN,
  parameter int unsigned     ADDR_W   = REG_ADDR_W,
  parameter logic [N-1:0]    SP_RESET = SP_RESET_VAL,
  parameter logic [N-1:0]    GP_RESET = GP_RESET_VAL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] write_reg_i,
  input  logic [N-1:0]      write_data_i,
  input  logic [ADDR_W-1:0] read_reg1_i,
  input  logic [ADDR_W-1:0] read_reg2_i,
  output logic [N-1:0]      read_data1_o,
  output logic [N-1:0]      read_data2_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] write_en;
  logic [N-1:0]     entries [DEPTH];

  reg_write_decoder #(
    .ADDR_W(ADDR_W)
  ) u_decoder (
    .reg_write_i(reg_write_i),
    .write_reg_i(write_reg_i),
    .write_en_o (write_en)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [N-1:0] RESET_VAL = (i == REG_SP) ? SP_RESET :
                                         (i == REG_GP) ? GP_RESET : '0;
    logic [N-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q <= RESET_VAL;
      end else if (write_en[i]) begin
        q <= write_data_i;
      end
    end

    assign entries[i] = q;
  end

  // Bypass is gated by reset so reads during reset show only reset values.
  always_comb begin
    read_data1_o = entries[read_reg1_i];
    if (reset && reg_write_i && (write_reg_i == read_reg1_i)) begin
      read_data1_o = write_data_i;
    end
    if (read_reg1_i == '0) begin
      read_data1_o = '0;
    end
  end

  always_comb begin
    read_data2_o = entries[read_reg2_i];
    if (reset && reg_write_i && (write_reg_i == read_reg2_i)) begin
      read_data2_o = write_data_i;
    end
    if (read_reg2_i == '0) begin
      read_data2_o = '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// random traffic, compared against an array-based architectural model.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        reg_write_i;
  logic [4:0]  write_reg_i;
  logic [31:0] write_data_i;
  logic [4:0]  read_reg1_i;
  logic [4:0]  read_reg2_i;
  logic [31:0] read_data1_o;
  logic [31:0] read_data2_o;

  int unsigned total;
  int unsigned bad;
  logic [31:0] model [32];

  register_file dut (
    .clk         (clk),
    .reset       (reset),
    .reg_write_i (reg_write_i),
    .write_reg_i (write_reg_i),
    .write_data_i(write_data_i),
    .read_reg1_i (read_reg1_i),
    .read_reg2_i (read_reg2_i),
    .read_data1_o(read_data1_o),
    .read_data2_o(read_data2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = 32'h7FFF_EFFC;
    model[3] = 32'h1000_8000;
  endtask

  // Architectural read: x0 is zero, a live write to the same index is
  // visible immediately, otherwise the stored value.
  function automatic logic [31:0] expect_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (reset && reg_write_i && write_reg_i == idx) return write_data_i;
    return model[idx];
  endfunction

  task automatic model_commit();
    if (reset && reg_write_i && write_reg_i != 5'd0) model[write_reg_i] = write_data_i;
  endtask

  // Drive one cycle at negedge, check both ports before the edge, commit at posedge.
  task automatic step(input string tag, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    reg_write_i  = we;
    write_reg_i  = wa;
    write_data_i = wd;
    read_reg1_i  = ra1;
    read_reg2_i  = ra2;
    #2;
    chk({tag, "_rd1"}, read_data1_o, expect_read(ra1));
    chk({tag, "_rd2"}, read_data2_o, expect_read(ra2));
    @(posedge clk);
    model_commit();
  endtask

  initial begin
    logic [4:0] wa, ra1, ra2;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    reg_write_i  = 1'b0;
    write_reg_i  = '0;
    write_data_i = '0;
    read_reg1_i  = '0;
    read_reg2_i  = '0;
    model_reset();

    // Reset held: write attempt to x1 must be discarded, x1 reads 0 despite bypass match.
    @(negedge clk);
    reg_write_i = 1'b1; write_reg_i = 5'd1; write_data_i = 32'hCAFE_F00D;
    read_reg1_i = 5'd1; read_reg2_i = 5'd2;
    #2;
    chk("rst_x1_nobypass", read_data1_o, 32'h0);
    chk("rst_x2", read_data2_o, 32'h7FFF_EFFC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reg_write_i = 1'b0;
    #3 reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      read_reg1_i = 5'(i);
      read_reg2_i = 5'(31 - i);
      #2;
      chk("reset_sweep_p1", read_data1_o, model[i]);
      chk("reset_sweep_p2", read_data2_o, model[31 - i]);
    end

    step("wr_x5",      1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6);
    step("rdback_x5",  1'b0, 5'd5, 32'h0,         5'd5, 5'd6);
    chk("x5_model_sanity", read_data1_o, 32'hDEAD_BEEF);

    step("wr_x0",      1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    step("rd_x0_a",    1'b0, 5'd0, 32'h0,         5'd0, 5'd0);
    step("rd_x0_b",    1'b1, 5'd3, 32'h0000_0777, 5'd0, 5'd3);

    step("wr_x7_init", 1'b1, 5'd7, 32'h11, 5'd7, 5'd7);
    step("x7_hold",    1'b0, 5'd7, 32'h0,  5'd7, 5'd7);
    step("x7_bypass",  1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    chk("bypass_p1_lit", read_data1_o, 32'h22);
    step("x7_after",   1'b0, 5'd7, 32'h0,  5'd7, 5'd7);
    chk("after_p2_lit", read_data2_o, 32'h22);

    step("b2b_a", 1'b1, 5'd8, 32'h0000_00A1, 5'd8, 5'd8);
    step("b2b_b", 1'b1, 5'd8, 32'h0000_00B2, 5'd8, 5'd8);
    step("b2b_c", 1'b0, 5'd8, 32'h0,         5'd8, 5'd8);

    for (int k = 0; k < 3; k++) begin
      step("wdis_x9", 1'b0, 5'd9, 32'hAAAA_5555, 5'd9, 5'd9);
      chk("wdis_lit", read_data1_o, 32'h0);
    end

    step("wr_x10",  1'b1, 5'd10, 32'h0000_1234, 5'd10, 5'd2);
    step("rd_x10",  1'b0, 5'd10, 32'h0,         5'd10, 5'd2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_x10", read_data1_o, 32'h0);
    chk("midrst_x2",  read_data2_o, 32'h7FFF_EFFC);
    model_reset();
    #1 reset = 1'b1;

    for (int n = 0; n < 300; n++) begin
      wa  = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step("rand", 1'($urandom_range(0, 1)), wa, $urandom, ra1, ra2);
    end

    for (int i = 0; i < 32; i++) begin
      step("final_sweep", 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file for the RISC-V core: 32 entries of 32 bits, two asynchronous read ports and one synchronous write port. It sits between decode (which supplies the source and destination indices) and the execute/ALU operand muxes, and receives write-back data from the WB stage. Write-through bypass lets a value written in cycle N be read in the same cycle N, so the pipeline does not need a separate WB→ID forwarding path.

## Interface
- `N`, 32, data width of each entry
- `ADDR_W`, 5, index width; depth is 2^ADDR_W
- `SP_RESET`, 32'h7FFF_EFFC, reset value of x2 (sp)
- `GP_RESET`, 32'h1000_8000, reset value of x3 (gp)
- `clk`  input  1  clock, all state updates on rising edge
- `reset`  input  1  asynchronous, active-low
- `reg_write_i`  input  1  write enable from WB stage
- `write_reg_i`  input  ADDR_W  destination index
- `write_data_i`  input  N  write-back data
- `read_reg1_i`  input  ADDR_W  source index, port 1 (rs1)
- `read_reg2_i`  input  ADDR_W  source index, port 2 (rs2)
- `read_data1_o`  output  N  port 1 data
- `read_data2_o`  output  N  port 2 data

## Operation
- Reset (reset==0, asynchronous): every entry cleared to 0, except x2 ← SP_RESET and x3 ← GP_RESET. Reset overrides any write in progress; a write whose edge coincides with reset assertion is discarded.
- Write: on rising clk with reset==1, reg_write_i==1 and write_reg_i≠0, entry[write_reg_i] ← write_data_i. All other entries hold.
- x0: hardwired zero. Writes to index 0 are ignored in storage, and reads of index 0 always return 0, including during bypass.
- Read (each port independently, combinational):
  - If the index is 0, the output is 0.
  - Else if reg_write_i==1 and write_reg_i equals the index, the output is write_data_i (bypass).
  - Else the output is entry[index].
- Both ports may address the same entry; both then return identical data.
- Write decode is one-hot: at most one entry is enabled per cycle, and all enables are 0 when reg_write_i==0.
- During reset, read outputs reflect the reset values combinationally. x1 must read 0 even if bypass conditions are present, because bypass applies only when reset==1.

## Timing
- Read latency is 0 cycles: outputs settle combinationally from the indices, storage and write-port inputs.
- Write latency is 1 edge. Storage updates at the rising edge, but the new value is already visible on the read ports during the same cycle through bypass. In cycle N+1 it comes from storage.
- Back-to-back writes to the same index: the last edge wins, and each cycle's read sees that cycle's write_data_i.
- There are no handshake signals, and no stall or hold behaviour beyond reg_write_i==0.
- Reset is deasserted asynchronously. The first write is captured at the first rising edge after deassertion.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`=32 and `REG_ADDR_W`=5
  - the register index constants `REG_ZERO`=0, `REG_SP`=2, `REG_GP`=3
  - `SP_RESET_VAL` and `GP_RESET_VAL`, which feed the parameter defaults
- One sub-module, `reg_write_decoder`: ADDR_W→2^ADDR_W one-hot decoder gated by reg_write_i, with output bit 0 forced to 0.
- Storage is a generate loop of per-entry enabled registers with an asynchronous active-low reset. The reset value is selected per index: SP_RESET, GP_RESET, or 0.
- Each read port is one 32:1 mux followed by the bypass/zero override.

## Test plan
- Reset check: hold reset=0, then release. Read all 32 indices → x2=0x7FFF_EFFC, x3=0x1000_8000, all others 0.
- Write/readback: write x5←0xDEAD_BEEF (reg_write_i=1) for one edge, then set reg_write_i=0. The next cycle, read_reg1_i=5 → 0xDEAD_BEEF; read_reg2_i=6 → 0.
- x0 immunity: write x0←0xFFFF_FFFF with read_reg1_i=0 in the same cycle → read_data1_o=0, both that cycle and every later cycle.
- Bypass: x7 holds 0x11. In one cycle write x7←0x22 with read_reg1_i=read_reg2_i=7 → both outputs 0x22 before the edge, and 0x22 after it with reg_write_i=0.
- Write disable: reg_write_i=0, write_reg_i=9, write_data_i=0xAAAA_5555 for 3 edges → x9 stays 0 and read_data1_o never shows 0xAAAA_5555.
- Reset mid-operation: write x10←0x1234, then pulse reset low between edges → x10 reads 0 immediately (asynchronously) and x2 returns to 0x7FFF_EFFC.
